ara_eoc_regs: RTL and testbench

Memory-mapped end-of-computation and benchmark-status register block inside `ara_soc`, driven by CVA6 through the control AXI-Lite bus. It produces the `exit_o` word that the top-level bench polls: bit 0 means done, bits [63:1] are the tohost code. It also exposes a synchronised Ara busy flag, so kernels can poll for vector drain before stopping cycle counts. An optional hardware cycle counter brackets benchmark regions.

---
 rtl/ara_eoc_regs.sv | 189 ++++++++++++++++++
 tb/tb_ara_eoc_regs.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ara_eoc_regs.sv
// ara_eoc_regs: AXI-Lite EXIT / BUSY / CYCLES / CYC_CTRL register block for the Ara SoC.
// Define ARA_EOC_CYCLE_COUNTER_EN to build the benchmark cycle counter and its IDLE/RUN/DRAIN FSM.
module ara_eoc_regs #(
    parameter int unsigned AddrWidth = 64,
    parameter logic [63:0] BaseAddr  = 64'hD000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [63:0]          w_data_i,
    input  logic [7:0]           w_strb_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    output logic [1:0]           b_resp_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    output logic [63:0]          r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    input  logic                 ara_busy_i,
    output logic [63:0]          exit_o
);
    localparam logic [AddrWidth-1:0] LBase      = AddrWidth'(BaseAddr);
    localparam logic [1:0]           RespOkay   = 2'b00;
    localparam logic [1:0]           RespSlvErr = 2'b10;

    logic [63:0] r_exit;
    logic        r_busy;
    logic        r_b_valid;
    logic [1:0]  r_b_resp;
    logic        r_r_valid;
    logic [63:0] r_r_data;
    logic [1:0]  r_r_resp;

    logic        w_wr_acc;
    logic        w_rd_acc;
    logic        w_aw_hit;
    logic        w_ar_hit;
    logic [63:0] w_exit_d;
    logic [1:0]  w_b_resp;
    logic [63:0] w_r_data;
    logic [1:0]  w_r_resp;
    logic [63:0] w_cycles;
    logic        w_unused;

    assign w_unused   = ^{aw_addr_i[2:0], ar_addr_i[2:0]};
    assign w_aw_hit   = (aw_addr_i[AddrWidth-1:5] == LBase[AddrWidth-1:5]);
    assign w_ar_hit   = (ar_addr_i[AddrWidth-1:5] == LBase[AddrWidth-1:5]);
    assign w_wr_acc   = aw_valid_i && w_valid_i && !r_b_valid;
    assign w_rd_acc   = ar_valid_i && !r_r_valid;
    assign aw_ready_o = w_wr_acc;
    assign w_ready_o  = w_wr_acc;
    assign ar_ready_o = !r_r_valid;
    assign b_valid_o  = r_b_valid;
    assign b_resp_o   = r_b_resp;
    assign r_valid_o  = r_r_valid;
    assign r_data_o   = r_r_data;
    assign r_resp_o   = r_r_resp;
    assign exit_o     = r_exit;

`ifdef ARA_EOC_CYCLE_COUNTER_EN
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} cyc_state_e;
    cyc_state_e  r_state;
    cyc_state_e  w_state_d;
    logic [63:0] r_cnt;
    logic        w_run_wr;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    assign w_cycles = r_cnt;
`else
    assign w_cycles = '0;
`endif

    // EXIT becomes read-only once the done bit is set; the write still completes OKAY.
    always_comb begin
        w_exit_d = r_exit;
        w_b_resp = RespOkay;
`ifdef ARA_EOC_CYCLE_COUNTER_EN
        w_run_wr = 1'b0;
`endif
        if (!w_aw_hit) begin
            w_b_resp = RespSlvErr;
        end else begin
            case (aw_addr_i[4:3])
                2'd0: begin
                    if (!r_exit[0]) begin
                        for (int unsigned i = 0; i < 8; i++) begin
                            if (w_strb_i[i]) w_exit_d[8*i +: 8] = w_data_i[8*i +: 8];
                        end
                    end
                end
                2'd1, 2'd2: w_b_resp = RespSlvErr;
                default: begin
`ifdef ARA_EOC_CYCLE_COUNTER_EN
                    w_run_wr = w_wr_acc && w_strb_i[0];
`endif
                end
            endcase
        end
    end

    always_comb begin
        w_r_data = '0;
        w_r_resp = RespOkay;
        if (!w_ar_hit) begin
            w_r_resp = RespSlvErr;
        end else begin
            case (ar_addr_i[4:3])
                2'd0:    w_r_data = r_exit;
                2'd1:    w_r_data = {63'd0, r_busy};
                2'd2:    w_r_data = w_cycles;
                default: w_r_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_exit    <= '0;
            r_busy    <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_resp  <= '0;
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= '0;
        end else begin
            r_busy <= ara_busy_i;
            if (w_wr_acc) begin
                r_exit    <= w_exit_d;
                r_b_valid <= 1'b1;
                r_b_resp  <= w_b_resp;
            end else if (b_ready_i) begin
                r_b_valid <= 1'b0;
            end
            if (w_rd_acc) begin
                r_r_valid <= 1'b1;
                r_r_data  <= w_r_data;
                r_r_resp  <= w_r_resp;
            end else if (r_ready_i) begin
                r_r_valid <= 1'b0;
            end
        end
    end

`ifdef ARA_EOC_CYCLE_COUNTER_EN
    // DRAIN keeps counting until the registered busy flag shows the vector unit has emptied.
    always_comb begin
        w_state_d = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_run_wr && w_data_i[0]) begin
                    w_state_d = RUN;
                    w_cnt_clr = 1'b1;
                end
            end
            RUN: begin
                w_cnt_inc = 1'b1;
                if (w_run_wr && !w_data_i[0]) w_state_d = DRAIN;
            end
            DRAIN: begin
                w_cnt_inc = r_busy;
                if (w_run_wr && w_data_i[0]) w_state_d = RUN;
                else if (!r_busy)            w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_cnt_clr)                     r_cnt <= '0;
            else if (w_cnt_inc && r_cnt != '1) r_cnt <= r_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ara_eoc_regs.sv
// Directed bench for ara_eoc_regs with a transaction-level register-map model checked every cycle.
module tb_ara_eoc_regs;
    localparam logic [63:0] BASE   = 64'hD000_0000;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] aw_addr = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready_o;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_valid = 1'b0;
    logic        w_ready_o;
    logic [1:0]  b_resp_o;
    logic        b_valid_o;
    logic        b_ready = 1'b1;
    logic [63:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_valid_o;
    logic        r_ready = 1'b1;
    logic        ara_busy = 1'b0;
    logic [63:0] exit_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ara_eoc_regs #(.AddrWidth(64), .BaseAddr(BASE)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready),
        .ara_busy_i(ara_busy), .exit_o(exit_o)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic in_win(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'd32);
    endfunction

    // Reference model: register map state as seen by software.
    logic [63:0] m_exit;
    logic        m_busy;
    logic        m_bvalid;
    logic [1:0]  m_bresp;
    logic        m_rvalid;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [63:0] m_cnt;
    logic        m_on;
    logic        m_drain;

    always @(negedge clk) begin : cmp
        logic wacc, racc, inc, n_on, n_drain;
        logic [63:0] n_exit, n_cnt;
        int idx;
        if (!rst_n) begin
            m_exit = '0; m_busy = 1'b0; m_bvalid = 1'b0; m_bresp = OKAY;
            m_rvalid = 1'b0; m_rdata = '0; m_rresp = OKAY;
            m_cnt = '0; m_on = 1'b0; m_drain = 1'b0;
        end else begin
            wacc = aw_valid && w_valid && !m_bvalid;
            racc = ar_valid && !m_rvalid;
            check64("aw_ready", {63'd0, aw_ready_o}, {63'd0, wacc});
            check64("w_ready", {63'd0, w_ready_o}, {63'd0, wacc});
            check64("ar_ready", {63'd0, ar_ready_o}, {63'd0, !m_rvalid});
            check64("b_valid", {63'd0, b_valid_o}, {63'd0, m_bvalid});
            check64("r_valid", {63'd0, r_valid_o}, {63'd0, m_rvalid});
            check64("exit_o", exit_o, m_exit);
            if (m_bvalid) check64("b_resp", {62'd0, b_resp_o}, {62'd0, m_bresp});
            if (m_rvalid) begin
                check64("r_data", r_data_o, m_rdata);
                check64("r_resp", {62'd0, r_resp_o}, {62'd0, m_rresp});
            end
            if (racc) begin
                m_rdata = '0;
                m_rresp = SLVERR;
                if (in_win(ar_addr)) begin
                    m_rresp = OKAY;
                    idx = int'((ar_addr - BASE) / 64'd8);
                    if (idx == 0) m_rdata = m_exit;
                    if (idx == 1) m_rdata = {63'd0, m_busy};
`ifdef ARA_EOC_CYCLE_COUNTER_EN
                    if (idx == 2) m_rdata = m_cnt;
`endif
                end
            end
            m_rvalid = racc ? 1'b1 : (r_ready ? 1'b0 : m_rvalid);
            n_exit  = m_exit;
            inc     = m_on && (!m_drain || m_busy);
            n_cnt   = (inc && m_cnt != ONES) ? m_cnt + 64'd1 : m_cnt;
            n_on    = (m_on && m_drain && !m_busy) ? 1'b0 : m_on;
            n_drain = m_drain;
            if (wacc) begin
                m_bresp = SLVERR;
                if (in_win(aw_addr)) begin
                    idx = int'((aw_addr - BASE) / 64'd8);
                    if (idx == 0 || idx == 3) m_bresp = OKAY;
                    if (idx == 0 && !m_exit[0])
                        for (int b = 0; b < 8; b++)
                            if (w_strb[b]) n_exit[8*b +: 8] = w_data[8*b +: 8];
`ifdef ARA_EOC_CYCLE_COUNTER_EN
                    if (idx == 3 && w_strb[0]) begin
                        if (w_data[0]) begin
                            if (!m_on) n_cnt = '0;
                            n_on = 1'b1;
                            n_drain = 1'b0;
                        end else if (m_on && !m_drain) begin
                            n_drain = 1'b1;
                        end
                    end
`endif
                end
            end
            m_bvalid = wacc ? 1'b1 : (b_ready ? 1'b0 : m_bvalid);
            m_exit = n_exit;
            m_cnt = n_cnt; m_on = n_on; m_drain = n_drain;
            m_busy = ara_busy;
        end
    end

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            output logic [1:0] resp, output int unsigned t_acc);
        int k;
        @(posedge clk); #1;
        aw_addr = addr; w_data = data; w_strb = strb; aw_valid = 1'b1; w_valid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!aw_ready_o && k < 20);
        check64("aw_accept_bound", {63'd0, aw_ready_o}, 64'd1);
        t_acc = cyc + 1;
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!(b_valid_o && b_ready) && k < 20);
        check64("b_valid_bound", {63'd0, b_valid_o}, 64'd1);
        resp = b_resp_o;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [63:0] addr, output logic [63:0] data,
                           output logic [1:0] resp, output int unsigned t_acc);
        int k;
        @(posedge clk); #1;
        ar_addr = addr; ar_valid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!ar_ready_o && k < 20);
        check64("ar_accept_bound", {63'd0, ar_ready_o}, 64'd1);
        t_acc = cyc + 1;
        @(posedge clk); #1;
        ar_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!(r_valid_o && r_ready) && k < 20);
        check64("r_valid_bound", {63'd0, r_valid_o}, 64'd1);
        data = r_data_o; resp = r_resp_o;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  rs;
        int unsigned t1, t0, tr, td;

        repeat (2) @(negedge clk);
        check64("rst_exit_o", exit_o, 64'd0);
        check64("rst_b_valid", {63'd0, b_valid_o}, 64'd0);
        check64("rst_r_valid", {63'd0, r_valid_o}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_read(BASE + 64'(8 * i), d, rs, t1);
            check64("reset_read_data", d, 64'd0);
            check64("reset_read_resp", {62'd0, rs}, {62'd0, OKAY});
        end

        // B held off: second write waits, then lands the cycle after the B handshake.
        b_ready = 1'b0;
        @(posedge clk); #1;
        aw_addr = BASE; w_data = 64'h10; w_strb = 8'hFF; aw_valid = 1'b1; w_valid = 1'b1;
        @(negedge clk); check64("hold_first_accept", {63'd0, aw_ready_o}, 64'd1);
        @(posedge clk); #1 w_data = 64'h20;
        repeat (5) begin
            @(negedge clk);
            check64("hold_b_valid", {63'd0, b_valid_o}, 64'd1);
            check64("hold_aw_ready", {63'd0, aw_ready_o}, 64'd0);
            check64("hold_w_ready", {63'd0, w_ready_o}, 64'd0);
        end
        check64("hold_exit", exit_o, 64'h10);
        @(posedge clk); #1 b_ready = 1'b1;
        @(negedge clk); check64("b2b_not_same_cycle", {63'd0, aw_ready_o}, 64'd0);
        @(negedge clk); check64("b2b_next_cycle", {63'd0, aw_ready_o}, 64'd1);
        @(posedge clk); #1 aw_valid = 1'b0; w_valid = 1'b0;
        @(negedge clk);
        check64("b2b_exit", exit_o, 64'h20);
        check64("b2b_resp", {62'd0, b_resp_o}, {62'd0, OKAY});
        @(posedge clk); #1;

        do_write(BASE, 64'h1111_2222_3333_4444, 8'hF0, rs, t1);
        check64("strb_exit", exit_o, 64'h1111_2222_0000_0020);

        do_read(BASE + 64'h40, d, rs, t1);
        check64("oor_read_data", d, 64'd0);
        check64("oor_read_resp", {62'd0, rs}, {62'd0, SLVERR});
        do_write(BASE + 64'h08, 64'h1, 8'hFF, rs, t1);
        check64("busy_write_resp", {62'd0, rs}, {62'd0, SLVERR});
        do_write(BASE + 64'h10, 64'h1, 8'hFF, rs, t1);
        check64("cycles_write_resp", {62'd0, rs}, {62'd0, SLVERR});
        do_write(BASE + 64'h20, 64'h1, 8'hFF, rs, t1);
        check64("oor_write_resp", {62'd0, rs}, {62'd0, SLVERR});
        do_write(BASE - 64'h08, 64'h1, 8'hFF, rs, t1);
        check64("below_write_resp", {62'd0, rs}, {62'd0, SLVERR});
        check64("oor_no_change", exit_o, 64'h1111_2222_0000_0020);

        @(posedge clk); #1 ara_busy = 1'b1;
        do_read(BASE + 64'h08, d, rs, t1);
        check64("busy_read_1", d, 64'd1);
        @(posedge clk); #1 ara_busy = 1'b0;
        repeat (2) @(posedge clk);
        do_read(BASE + 64'h08, d, rs, t1);
        check64("busy_read_0", d, 64'd0);

`ifdef ARA_EOC_CYCLE_COUNTER_EN
        do_write(BASE + 64'h18, 64'h1, 8'h01, rs, t1);
        check64("run_write_resp", {62'd0, rs}, {62'd0, OKAY});
        repeat (10) @(posedge clk);
        #1 ara_busy = 1'b1;
        do_write(BASE + 64'h18, 64'h0, 8'h01, rs, t0);
        repeat (3) @(posedge clk);
        #1 ara_busy = 1'b0; td = cyc;
        repeat (6) @(posedge clk);
        do_read(BASE + 64'h10, d, rs, tr);
        check64("drain_count", d, 64'(td + 1 - t1));
        do_read(BASE + 64'h18, d, rs, tr);
        check64("cyc_ctrl_reads_0", d, 64'd0);

        do_write(BASE + 64'h18, 64'h1, 8'h01, rs, t1);
        do_write(BASE + 64'h18, 64'h0, 8'h01, rs, t0);
        repeat (4) @(posedge clk);
        do_read(BASE + 64'h10, d, rs, tr);
        check64("nobusy_count", d, 64'(t0 - t1));

        do_write(BASE + 64'h18, 64'h1, 8'h01, rs, t1);
        @(posedge clk); #1 ara_busy = 1'b1;
        do_write(BASE + 64'h18, 64'h0, 8'h01, rs, t0);
        do_write(BASE + 64'h18, 64'h1, 8'h01, rs, t0);
        #1 ara_busy = 1'b0;
        repeat (3) @(posedge clk);
        do_read(BASE + 64'h10, d, rs, tr);
        check64("rerun_no_clear", d, 64'(tr - 1 - t1));

        @(posedge clk); #2;
        force dut.r_cnt = 64'hFFFF_FFFF_FFFF_FFFC;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFC;
        #1 release dut.r_cnt;
        repeat (6) @(posedge clk);
        do_read(BASE + 64'h10, d, rs, tr);
        check64("saturate", d, ONES);
        do_write(BASE + 64'h18, 64'h0, 8'h01, rs, t0);
        repeat (3) @(posedge clk);
        do_write(BASE + 64'h18, 64'h1, 8'hFE, rs, t0);
        repeat (3) @(posedge clk);
        do_read(BASE + 64'h10, d, rs, tr);
        check64("no_strb0_no_effect", d, ONES);
`else
        do_write(BASE + 64'h18, 64'h1, 8'h01, rs, t1);
        check64("ctrl_write_resp", {62'd0, rs}, {62'd0, OKAY});
        repeat (5) @(posedge clk);
        do_read(BASE + 64'h10, d, rs, t1);
        check64("cycles_zero", d, 64'd0);
        check64("cycles_resp", {62'd0, rs}, {62'd0, OKAY});
`endif

        do_write(BASE, 64'h1, 8'hFF, rs, t1);
        check64("exit_done", exit_o, 64'h1);
        do_write(BASE, 64'h7, 8'hFF, rs, t1);
        check64("sticky_resp", {62'd0, rs}, {62'd0, OKAY});
        check64("sticky_exit", exit_o, 64'h1);
        do_read(BASE, d, rs, t1);
        check64("sticky_read", d, 64'h1);

        b_ready = 1'b0; r_ready = 1'b0;
        @(posedge clk); #1;
        aw_addr = BASE; w_data = 64'h9; w_strb = 8'hFF; aw_valid = 1'b1; w_valid = 1'b1;
        ar_addr = BASE; ar_valid = 1'b1;
        @(posedge clk); #1 aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        @(negedge clk);
        check64("pre_rst_b_valid", {63'd0, b_valid_o}, 64'd1);
        check64("pre_rst_r_valid", {63'd0, r_valid_o}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check64("mid_rst_b_valid", {63'd0, b_valid_o}, 64'd0);
        check64("mid_rst_r_valid", {63'd0, r_valid_o}, 64'd0);
        check64("mid_rst_exit", exit_o, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
        repeat (2) @(negedge clk);
        check64("post_rst_b_valid", {63'd0, b_valid_o}, 64'd0);

        @(posedge clk); #1;
        aw_addr = BASE; w_data = 64'h7; w_strb = 8'hFF; aw_valid = 1'b1; w_valid = 1'b1;
        ar_addr = BASE; ar_valid = 1'b1;
        @(negedge clk);
        check64("same_cycle_aw", {63'd0, aw_ready_o}, 64'd1);
        check64("same_cycle_ar", {63'd0, ar_ready_o}, 64'd1);
        @(posedge clk); #1 aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        @(negedge clk);
        check64("rw_old_value", r_data_o, 64'd0);
        check64("exit_fail_code", exit_o, 64'h7);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
